// File: rtl/rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Shares one single-port memory bus between instruction fetch and the
// MEM-stage load/store unit. One transaction is outstanding at a time. Data
// accesses win arbitration by default. A saturating starvation counter lets a
// waiting fetch win once IF_STARVE_LIMIT data grants have gone by. Byte
// enables and store-lane replication come from the access size. Misaligned or
// illegal accesses get an error response and never reach memory.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req_i / if_addr_i        fetch request and word address
//   if_gnt_o                    fetch accepted (combinational, IDLE only)
//   if_rvalid_o / if_rdata_o    fetch response (pass-through from memory)
//   if_err_o                    fetch misaligned, qualified by if_rvalid_o
//   d_req_i / d_we_i            data request, 1 = store
//   d_size_i                    0 byte, 1 half, 2 word, 3 illegal
//   d_addr_i / d_wdata_i        byte address, right-aligned store data
//   d_gnt_o                     data accepted (combinational, IDLE only)
//   d_rvalid_o / d_rdata_o      data response, load word shifted by offset
//   d_err_o                     misaligned/illegal, qualified by d_rvalid_o
//   mem_req_o .. mem_wdata_o    registered memory request
//   mem_gnt_i, mem_rvalid_i     memory handshake
//   mem_rdata_i                 memory read word
// -----------------------------------------------------------------------------
module rv32_mem_arbiter #(
  parameter int unsigned IF_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  // load/store unit
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_size_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  // memory bus
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    ERR_RSP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  // Two extra codes keep the counter at least one bit wide for a zero limit.
  localparam int unsigned CNT_W = $clog2(IF_STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_STARVE_LIMIT);

  state_e           state;
  logic             owner_d;     // 1 = current transaction belongs to data port
  logic [1:0]       d_off;       // byte offset of the current data access
  logic [CNT_W-1:0] starve_cnt;

  logic        sel_if;
  logic        sel_d;
  logic        if_misal;
  logic        d_misal;
  logic [3:0]  d_be;
  logic [31:0] d_wdata_rep;

  // ---------------------------------------------------------------------------
  // Selection, alignment check and lane generation
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    d_misal     = 1'b1;
    d_be        = 4'b0000;
    d_wdata_rep = d_wdata_i;

    sel_if   = if_req_i && (!d_req_i || starve_cnt == CNT_MAX);
    sel_d    = d_req_i && !sel_if;
    if_misal = |if_addr_i[1:0];

    case (d_size_i)
      SIZE_BYTE: begin
        d_misal     = 1'b0;
        d_be        = 4'b0001 << d_addr_i[1:0];
        d_wdata_rep = {4{d_wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        d_misal     = d_addr_i[0];
        d_be        = 4'b0011 << d_addr_i[1:0];
        d_wdata_rep = {2{d_wdata_i[15:0]}};
      end
      SIZE_WORD: begin
        d_misal     = |d_addr_i[1:0];
        d_be        = 4'b1111;
        d_wdata_rep = d_wdata_i;
      end
      default: begin
        d_misal     = 1'b1;
        d_be        = 4'b0000;
        d_wdata_rep = d_wdata_i;
      end
    endcase
  end

  assign if_gnt_o = (state == IDLE) && sel_if;
  assign d_gnt_o  = (state == IDLE) && sel_d;

  // ---------------------------------------------------------------------------
  // Responses: memory data passes straight through to the owner; an error
  // response carries zero data.
  // ---------------------------------------------------------------------------
  logic mem_rsp;
  assign mem_rsp = (state == WAIT_RSP) && mem_rvalid_i;

  assign if_rvalid_o = !owner_d && (mem_rsp || state == ERR_RSP);
  assign if_err_o    = !owner_d && (state == ERR_RSP);
  assign if_rdata_o  = (!owner_d && mem_rsp) ? mem_rdata_i : 32'h0;

  assign d_rvalid_o = owner_d && (mem_rsp || state == ERR_RSP);
  assign d_err_o    = owner_d && (state == ERR_RSP);
  assign d_rdata_o  = (owner_d && mem_rsp) ? (mem_rdata_i >> {d_off, 3'b000}) : 32'h0;

  // ---------------------------------------------------------------------------
  // FSM, request registers and starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all control and bus registers are reset so an abort mid-transaction
    // leaves a clean, quiet bus and a late memory response finds IDLE.
    if (!rst_n) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      d_off       <= 2'b00;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      unique case (state)
        IDLE: begin
          if (sel_if) begin
            owner_d    <= 1'b0;
            d_off      <= 2'b00;
            starve_cnt <= '0;
            if (if_misal) begin
              state <= ERR_RSP;
            end else begin
              state       <= WAIT_GNT;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_be_o    <= 4'b1111;
              mem_addr_o  <= {if_addr_i[31:2], 2'b00};
              mem_wdata_o <= 32'h0;
            end
          end else if (sel_d) begin
            owner_d <= 1'b1;
            d_off   <= d_addr_i[1:0];
            if (if_req_i && starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (d_misal) begin
              state <= ERR_RSP;
            end else begin
              state       <= WAIT_GNT;
              mem_req_o   <= 1'b1;
              mem_we_o    <= d_we_i;
              mem_be_o    <= d_be;
              mem_addr_o  <= {d_addr_i[31:2], 2'b00};
              mem_wdata_o <= d_wdata_rep;
            end
          end
        end
        WAIT_GNT: begin
          if (mem_gnt_i) begin
            state     <= WAIT_RSP;
            mem_req_o <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
          end
        end
        ERR_RSP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv32_mem_arbiter
//
// Directed bench for rv32_mem_arbiter. Inputs change 1 ns after a rising
// edge; outputs are sampled a further 1 ns later, well clear of both edges.
// -----------------------------------------------------------------------------
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  rv32_mem_arbiter #(.IF_STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .if_err_o     (if_err_o),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_size_i     (d_size_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_gnt_o      (d_gnt_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .d_err_o      (d_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Every output quiet: no grants, no responses, bus registers at zero.
  task automatic check_quiet(input string tag);
    check({tag, " gnt"},    {30'h0, if_gnt_o, d_gnt_o}, 32'h0);
    check({tag, " rvalid"}, {30'h0, if_rvalid_o, d_rvalid_o}, 32'h0);
    check({tag, " err"},    {30'h0, if_err_o, d_err_o}, 32'h0);
    check({tag, " rdata"},  if_rdata_o | d_rdata_o, 32'h0);
    check({tag, " memctl"}, {26'h0, mem_req_o, mem_we_o, mem_be_o}, 32'h0);
    check({tag, " memaddr"}, mem_addr_o, 32'h0);
    check({tag, " memwdata"}, mem_wdata_o, 32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    d_req_i      = 1'b0;
    d_we_i       = 1'b0;
    d_size_i     = 2'd0;
    d_addr_i     = 32'h0;
    d_wdata_i    = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;

    // ---- reset ----
    step(); step();
    check_quiet("reset");
    rst_n = 1'b1;
    step(); settle();
    check_quiet("post_reset");

    // ---- single fetch at 0x100, zero-wait memory ----
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0100;
    settle();
    check("fetch gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h2);
    check("fetch no_req_yet", {31'h0, mem_req_o}, 32'h0);
    step();
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b1;
    settle();
    check("fetch mem_req", {31'h0, mem_req_o}, 32'h1);
    check("fetch mem_addr", mem_addr_o, 32'h0000_0100);
    check("fetch be_we", {27'h0, mem_we_o, mem_be_o}, 32'h0F);
    check("fetch no_gnt_busy", {30'h0, if_gnt_o, d_gnt_o}, 32'h0);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0050_0093;
    settle();
    check("fetch mem_req_drop", {31'h0, mem_req_o}, 32'h0);
    check("fetch rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h2);
    check("fetch rdata", if_rdata_o, 32'h0050_0093);
    check("fetch err", {31'h0, if_err_o}, 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    settle();
    check("fetch idle_rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h0);

    // ---- byte store at 0x203, one memory wait state ----
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_size_i  = 2'd0;
    d_addr_i  = 32'h0000_0203;
    d_wdata_i = 32'h0000_00A5;
    settle();
    check("bstore gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h1);
    step();
    d_req_i      = 1'b0;
    mem_rvalid_i = 1'b1;   // stray response while waiting for grant
    settle();
    check("bstore mem_req", {31'h0, mem_req_o}, 32'h1);
    check("bstore be_we", {27'h0, mem_we_o, mem_be_o}, 32'h18);
    check("bstore wdata", mem_wdata_o, 32'hA5A5_A5A5);
    check("bstore addr", mem_addr_o, 32'h0000_0200);
    check("bstore stray_rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    settle();
    check("bstore req_held", {31'h0, mem_req_o}, 32'h1);
    check("bstore wdata_held", mem_wdata_o, 32'hA5A5_A5A5);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_2222;
    settle();
    check("bstore rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h1);
    check("bstore err", {31'h0, d_err_o}, 32'h0);
    step();
    mem_rvalid_i = 1'b0;

    // ---- half load at 0x42 ----
    d_req_i  = 1'b1;
    d_we_i   = 1'b0;
    d_size_i = 2'd1;
    d_addr_i = 32'h0000_0042;
    settle();
    check("hload gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h1);
    step();
    d_req_i   = 1'b0;
    mem_gnt_i = 1'b1;
    settle();
    check("hload be_we", {27'h0, mem_we_o, mem_be_o}, 32'h0C);
    check("hload addr", mem_addr_o, 32'h0000_0040);
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBEEF_1234;
    settle();
    check("hload rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h1);
    check("hload rdata", d_rdata_o, 32'h0000_BEEF);
    check("hload err", {31'h0, d_err_o}, 32'h0);
    step();
    mem_rvalid_i = 1'b0;

    // ---- misaligned word load at 0x6 ----
    d_req_i  = 1'b1;
    d_size_i = 2'd2;
    d_addr_i = 32'h0000_0006;
    settle();
    check("mis_word gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h1);
    step();
    d_req_i = 1'b0;
    settle();
    check("mis_word no_req", {31'h0, mem_req_o}, 32'h0);
    check("mis_word rsp", {29'h0, d_rvalid_o, d_err_o, if_rvalid_o}, 32'h6);
    check("mis_word rdata", d_rdata_o, 32'h0);
    step(); settle();
    check("mis_word idle", {30'h0, d_rvalid_o, mem_req_o}, 32'h0);

    // ---- illegal size 3 at 0x0 ----
    d_req_i  = 1'b1;
    d_size_i = 2'd3;
    d_addr_i = 32'h0000_0000;
    settle();
    check("size3 gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h1);
    step();
    d_req_i = 1'b0;
    settle();
    check("size3 no_req", {31'h0, mem_req_o}, 32'h0);
    check("size3 rsp", {29'h0, d_rvalid_o, d_err_o, if_rvalid_o}, 32'h6);
    step();

    // ---- misaligned fetch at 0x102 ----
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0102;
    settle();
    check("mis_fetch gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h2);
    step();
    if_req_i = 1'b0;
    settle();
    check("mis_fetch rsp", {28'h0, mem_req_o, if_rvalid_o, if_err_o, d_rvalid_o}, 32'h6);
    check("mis_fetch rdata", if_rdata_o, 32'h0);
    step();

    // ---- contention: both requesters held, memory always ready ----
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0000;
    d_req_i      = 1'b1;
    d_we_i       = 1'b0;
    d_size_i     = 2'd2;
    d_addr_i     = 32'h0000_0010;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0;
    settle();
    for (int i = 0; i < 10; i++) begin
      // Expected grant order D,D,D,D,I,D,D,D,D,I: {if_gnt, d_gnt}
      check($sformatf("contend grant%0d", i), {30'h0, if_gnt_o, d_gnt_o},
            (i == 4 || i == 9) ? 32'h2 : 32'h1);
      step(); step(); step(); settle();
    end
    if_req_i     = 1'b0;
    d_req_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    step(); step(); step();

    // ---- reset during WAIT_RSP, late response after release ----
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0200;
    settle();
    check("rst_abort gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h2);
    step();
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;        // now in WAIT_RSP, response outstanding
    settle();
    rst_n = 1'b0;
    settle();
    check_quiet("rst_abort in_reset");
    step();
    rst_n        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    settle();
    check_quiet("rst_abort late_rsp");
    step();
    mem_rvalid_i = 1'b0;
    d_req_i      = 1'b1;
    d_size_i     = 2'd2;
    d_addr_i     = 32'h0000_0020;
    settle();
    check("rst_abort idle_gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h1);
    step();
    d_req_i = 1'b0;
    settle();
    check("rst_abort new_req", {31'h0, mem_req_o}, 32'h1);
    check("rst_abort new_addr", mem_addr_o, 32'h0000_0020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Arbitrates one unified single-port memory bus between the instruction-fetch stage and the MEM-stage load/store unit of the rv32 pipeline. It runs one outstanding transaction at a time and gives data accesses priority, with a starvation limit that protects fetch. It also generates byte enables and write-lane replication from `mem_size_e`, and reports misaligned accesses as error responses without touching memory.

## Interface
Parameters:
- `IF_STARVE_LIMIT`, default 4: number of consecutive data grants, made while fetch is waiting, after which fetch wins the next contested arbitration.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req_i`  in  1  fetch request; held until `if_gnt_o`.
- `if_addr_i`  in  32  fetch address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch response valid.
- `if_rdata_o`  out  32  fetched instruction word.
- `if_err_o`  out  1  fetch misaligned; qualified by `if_rvalid_o`.
- `d_req_i`  in  1  data request; held until `d_gnt_o`.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_size_i`  in  2  `mem_size_e`: BYTE=0, HALF=1, WORD=2; 3 is illegal.
- `d_addr_i`  in  32  data byte address.
- `d_wdata_i`  in  32  store data, right-aligned.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  data response valid; asserted for stores as well as loads.
- `d_rdata_o`  out  32  load word shifted right by `8*addr[1:0]`, unextended.
- `d_err_o`  out  1  misaligned or illegal size; qualified by `d_rvalid_o`.
- `mem_req_o`  out  1  memory request, registered.
- `mem_we_o`  out  1  memory write enable, registered.
- `mem_be_o`  out  4  byte enables, registered.
- `mem_addr_o`  out  32  word address: `{addr[31:2],2'b00}`, registered.
- `mem_wdata_o`  out  32  lane-replicated store data, registered.
- `mem_gnt_i`  in  1  memory accepts `mem_req_o`.
- `mem_rvalid_i`  in  1  memory response; arrives no earlier than the cycle after `mem_gnt_i`.
- `mem_rdata_i`  in  32  memory read word.

## Operation
- FSM states:
  - IDLE → WAIT_GNT when a legal request is selected.
  - IDLE → ERR_RSP when the selected request is misaligned or illegal.
  - WAIT_GNT → WAIT_RSP on `mem_gnt_i`.
  - WAIT_RSP → IDLE on `mem_rvalid_i`.
  - ERR_RSP → IDLE unconditionally.
- Selection happens only in IDLE.
  - Data wins by default.
  - Fetch wins if `if_req_i && (!d_req_i || starve_cnt == IF_STARVE_LIMIT)`.
- Grant: the winner's `*_gnt_o` is high combinationally in the IDLE cycle of selection. The owner, address, write enable, byte enables and write data are latched at that edge.
- Starvation counter:
  - `starve_cnt` increments, saturating at the limit, on a data grant while `if_req_i`=1.
  - It clears on any fetch grant.
  - It holds otherwise.
- Misalignment checks:
  - Fetch: `addr[1:0]` ≠ 0.
  - Data half: `addr[0]` = 1.
  - Data word: `addr[1:0]` ≠ 0.
  - Data size 3: always an error.
- Byte enables, with `off = addr[1:0]`:
  - BYTE: `4'b0001 << off`, wdata `{4{wdata[7:0]}}`.
  - HALF: `4'b0011 << off`, wdata `{2{wdata[15:0]}}`.
  - WORD: `4'b1111`, wdata as given.
  - Fetch: `4'b1111`, `we`=0.
- Responses:
  - `*_rvalid_o = mem_rvalid_i` in WAIT_RSP, gated to the owner, combinational pass-through. Rdata is passed through likewise.
  - In ERR_RSP the owner gets `rvalid`=1, `err`=1, `rdata`=0.
- `mem_rvalid_i` or `mem_gnt_i` outside WAIT_RSP or WAIT_GNT respectively is ignored.
- Reset, including mid-transaction:
  - State returns to IDLE and `starve_cnt` to 0.
  - All registered outputs return to 0.
  - A late memory response is discarded.

## Timing
- All outputs are 0 during and immediately after reset.
- Zero-wait memory sequence:
  - Cycle 0: IDLE, `gnt` asserted.
  - Cycle 1: `mem_req_o`=1, `mem_gnt_i`=1.
  - Cycle 2: `mem_rvalid_i`=1, owner `rvalid`=1.
  - Cycle 3: IDLE, next arbitration.
- Minimum of 3 cycles per access.
- `mem_req_o` and all `mem_*` outputs are stable from WAIT_GNT entry until `mem_gnt_i`. `mem_req_o` drops in the cycle after the grant.
- Error path: grant in cycle 0, `rvalid`/`err` in cycle 1, IDLE in cycle 2. `mem_req_o` never asserts.
- There is no grant and no `rvalid` to a requester outside the defined states. At most one of `if_gnt_o` and `d_gnt_o` is high in any cycle.

## Test plan
- Single fetch: `if_addr`=0x100, `mem_rdata`=0x00500093 → `mem_addr_o`=0x100, `be`=1111, `if_rvalid_o` in cycle 2 with rdata 0x00500093, `if_err_o`=0.
- Byte store: `d_addr`=0x203, size BYTE, `wdata`=0xA5 → `mem_be_o`=1000, `mem_wdata_o`=0xA5A5A5A5, `mem_addr_o`=0x200, `d_rvalid_o`=1 and `err`=0.
- Half load: `d_addr`=0x42, `mem_rdata`=0xBEEF1234 → `d_rdata_o`=0x0000BEEF.
- Misaligned word load at 0x6 → no `mem_req_o`, `d_rvalid_o`=1 with `d_err_o`=1 one cycle after grant. Repeat with `d_size`=3 at 0x0 → same result.
- Contention: `if_req` and `d_req` held high continuously with `IF_STARVE_LIMIT`=4 → grants follow D,D,D,D,I,D,D,D,D,I.
- Reset during WAIT_RSP, then `mem_rvalid_i`=1 after release → no `rvalid` to either requester, all outputs 0, FSM in IDLE.
